// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared widths and encodings for the RV32I pipeline stages
package riscv_pipe_pkg;
  localparam int DEFAULT_XLEN = 32;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/execute_cycle_alu.sv
// alu: combinational RV32I ALU with zero flag, shared by any ALU-based stage
module alu
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic            w_lt;
  assign w_sum  = A + B;
  assign w_diff = A - B;
  assign w_lt   = $signed(A) < $signed(B);
  // operation select; unassigned codes yield zero
  always_comb begin
    Result = (ALUControl == ALU_ADD) ? w_sum :
             (ALUControl == ALU_SUB) ? w_diff :
             (ALUControl == ALU_AND) ? (A & B) :
             (ALUControl == ALU_OR)  ? (A | B) :
             (ALUControl == ALU_SLT) ? {{(XLEN-1){1'b0}}, w_lt} :
             '0;
    Zero   = (Result == '0);
  end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage - operand forwarding, ALU, branch resolve, EX/MEM register
module execute_cycle
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ALU_ResultM_fwd,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;
  logic            r_reg_write;
  logic            r_mem_write;
  logic            r_result_src;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;
  // forwarding muxes; select 11 falls back to the register-file operand
  always_comb begin
    w_src_a      = (ForwardA_E == FWD_WB)  ? ResultW :
                   (ForwardA_E == FWD_MEM) ? ALU_ResultM_fwd : RD1_E;
    w_write_data = (ForwardB_E == FWD_WB)  ? ResultW :
                   (ForwardB_E == FWD_MEM) ? ALU_ResultM_fwd : RD2_E;
    w_src_b      = ALUSrcE ? Imm_Ext_E : w_write_data;
  end
  alu #(.XLEN(XLEN)) u_alu (
    .A          (w_src_a),
    .B          (w_src_b),
    .ALUControl (ALUControlE),
    .Result     (w_alu_result),
    .Zero       (w_zero)
  );
  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + Imm_Ext_E;
  // EX/MEM pipeline register, captures every cycle, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd         <= RD_E;
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
    end
  end
  assign RegWriteM   = r_reg_write;
  assign MemWriteM   = r_mem_write;
  assign ResultSrcM  = r_result_src;
  assign RD_M        = r_rd;
  assign ALU_ResultM = r_alu_result;
  assign WriteDataM  = r_write_data;
  assign PCPlus4M    = r_pc_plus4;
endmodule
